// File: rtl/rock_sequencer_pkg.sv
// rock_pkg: shared state codes, default timing constants and datapath reload values
package rock_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    ROCK  = 2'd2,
    CALM  = 2'd3
  } state_t;
  localparam int SETTLE_TICKS_DEF = 8;
  localparam int CALM_TICKS_DEF = 16;
  localparam int F_MAX_DEF = 9;
  localparam logic [3:0] F_RELOAD = 4'd5;
  localparam logic [3:0] A_RELOAD = 4'd5;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/rock_sequencer_sync.sv
// rock_sync: two-flop level synchronizer with synchronous reset
module rock_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  // shift the raw level through two flops before anyone looks at it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_q <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/rock_sequencer.sv
// rock_sequencer: cry-driven control FSM issuing step pulses to the F/A datapath
module rock_sequencer
  import rock_pkg::*;
#(
  parameter int SETTLE_TICKS = SETTLE_TICKS_DEF,
  parameter int CALM_TICKS = CALM_TICKS_DEF,
  parameter int F_MAX = F_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       cry,
  input  logic [3:0] f_val,
  input  logic [3:0] a_val,
  input  logic       f0,
  input  logic       af0,
  output logic       dp_reset,
  output logic       f_up,
  output logic       f_down,
  output logic       a_down,
  output logic       motor_en,
  output logic [1:0] state
);
  localparam int TW = max2($clog2(max2(SETTLE_TICKS, CALM_TICKS)), 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_TICKS - 1);
  localparam logic [TW-1:0] CALM_LAST = TW'(CALM_TICKS - 1);
  localparam logic [3:0] F_CEIL = 4'(F_MAX);
  logic w_cry_s;
  logic w_unused;
  state_t r_state;
  logic [TW-1:0] r_timer;
  logic r_dp_reset;
  logic r_f_up;
  logic r_f_down;
  logic r_a_down;
  logic r_motor_en;
  // A is only observed through af0; the raw value is not needed for any decision
  assign w_unused = ^a_val;
  rock_sync u_cry_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (cry),
    .o_q   (w_cry_s)
  );
  // state, tick timer and registered pulse/motor outputs; every pulse defaults low so it lasts one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_dp_reset <= 1'b0;
      r_f_up <= 1'b0;
      r_f_down <= 1'b0;
      r_a_down <= 1'b0;
      r_motor_en <= 1'b0;
    end else begin
      r_dp_reset <= 1'b0;
      r_f_up <= 1'b0;
      r_f_down <= 1'b0;
      r_a_down <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          r_motor_en <= 1'b0;
          if (w_cry_s) begin
            r_state <= START;
            r_dp_reset <= 1'b1;
          end
        end
        START: begin
          r_state <= ROCK;
          r_timer <= '0;
          r_motor_en <= 1'b1;
        end
        ROCK: begin
          r_motor_en <= 1'b1;
          if (tick) begin
            if (r_timer == SETTLE_LAST) begin
              r_timer <= '0;
              if (!w_cry_s) r_state <= CALM;
              else if (f_val < F_CEIL) r_f_up <= 1'b1;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        CALM: begin
          if (w_cry_s) begin
            r_state <= ROCK;
            r_timer <= '0;
          end else if (tick) begin
            if (r_timer == CALM_LAST) begin
              r_timer <= '0;
              if (af0) begin
                r_state <= IDLE;
                r_motor_en <= 1'b0;
              end else if (!f0) begin
                r_f_down <= 1'b1;
              end else begin
                r_a_down <= 1'b1;
              end
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
          r_motor_en <= 1'b0;
        end
      endcase
    end
  end
  assign dp_reset = r_dp_reset;
  assign f_up = r_f_up;
  assign f_down = r_f_down;
  assign a_down = r_a_down;
  assign motor_en = r_motor_en;
  assign state = r_state;
endmodule

// File: tb/tb_rock_sequencer.sv
// tb_rock_sequencer: directed plus random checks of rock_sequencer against a behavioural model
module tb_rock_sequencer;
  import rock_pkg::*;
  localparam int S = SETTLE_TICKS_DEF;
  localparam int C = CALM_TICKS_DEF;
  localparam int FM = F_MAX_DEF;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic cry = 1'b0;
  logic [3:0] f_val = 4'd0;
  logic [3:0] a_val = 4'd0;
  logic f0 = 1'b1;
  logic af0 = 1'b1;
  logic dp_reset, f_up, f_down, a_down, motor_en;
  logic [1:0] state;
  int checks = 0;
  int failures = 0;
  int dp_f = 5;
  int dp_a = 5;
  int m_mode = 0;
  int m_left = 0;
  bit h1, h2;
  bit e_dp, e_up, e_dn, e_ad, e_mot;
  int n_up, n_dn, n_ad, n_dp;

  rock_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .cry      (cry),
    .f_val    (f_val),
    .a_val    (a_val),
    .f0       (f0),
    .af0      (af0),
    .dp_reset (dp_reset),
    .f_up     (f_up),
    .f_down   (f_down),
    .a_down   (a_down),
    .motor_en (motor_en),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // datapath reacts to the pulses present during the cycle ending at this edge
  task automatic dp_update();
    if (e_dp) begin
      dp_f = int'(F_RELOAD);
      dp_a = int'(A_RELOAD);
    end else if (e_up) dp_f = (dp_f + 1) & 15;
    else if (e_dn) dp_f = (dp_f - 1) & 15;
    else if (e_ad) dp_a = (dp_a - 1) & 15;
  endtask

  // rule-level model: mode 0 idle, 1 start, 2 rock, 3 calm; m_left counts ticks remaining to a decision
  task automatic model();
    bit cs;
    if (reset) begin
      m_mode = 0;
      m_left = 0;
      h1 = 0;
      h2 = 0;
      {e_dp, e_up, e_dn, e_ad, e_mot} = '0;
    end else begin
      cs = h2;
      h2 = h1;
      h1 = cry;
      {e_dp, e_up, e_dn, e_ad} = '0;
      if (m_mode == 0) begin
        if (cs) begin
          m_mode = 1;
          e_dp = 1;
        end
      end else if (m_mode == 1) begin
        m_mode = 2;
        m_left = S;
      end else if (m_mode == 2) begin
        if (tick) begin
          m_left--;
          if (m_left == 0) begin
            m_left = S;
            if (!cs) begin
              m_mode = 3;
              m_left = C;
            end else if (int'(f_val) < FM) e_up = 1;
          end
        end
      end else begin
        if (cs) begin
          m_mode = 2;
          m_left = S;
        end else if (tick) begin
          m_left--;
          if (m_left == 0) begin
            m_left = C;
            if (af0) m_mode = 0;
            else if (!f0) e_dn = 1;
            else e_ad = 1;
          end
        end
      end
      e_mot = (m_mode >= 2);
    end
  endtask

  task automatic step(input bit t, input bit c, input bit r);
    tick = t;
    cry = c;
    reset = r;
    f_val = 4'(dp_f);
    a_val = 4'(dp_a);
    f0 = (dp_f == 0);
    af0 = (dp_f == 0) && (dp_a == 0);
    @(posedge clk);
    dp_update();
    model();
    @(negedge clk);
    chk("state", 32'(state), 32'(m_mode));
    chk("motor_en", 32'(motor_en), 32'(e_mot));
    chk("dp_reset", 32'(dp_reset), 32'(e_dp));
    chk("f_up", 32'(f_up), 32'(e_up));
    chk("f_down", 32'(f_down), 32'(e_dn));
    chk("a_down", 32'(a_down), 32'(e_ad));
    chk("onehot", 32'(int'(dp_reset) + int'(f_up) + int'(f_down) + int'(a_down) <= 1), 32'd1);
    chk("fup_sat", 32'(f_up && int'(f_val) >= FM), 32'd0);
    n_up += int'(f_up);
    n_dn += int'(f_down);
    n_ad += int'(a_down);
    n_dp += int'(dp_reset);
  endtask

  initial begin
    int lat;
    int got;
    bit crv;
    repeat (3) step(0, 0, 1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_motor", 32'(motor_en), 32'd0);
    // cry rise to dp_reset latency and START -> ROCK
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      step(0, 1, 0);
      if (dp_reset === 1'b1) lat = i;
    end
    chk("dp_latency", 32'(lat), 32'd3);
    chk("start_state", 32'(state), 32'd1);
    step(0, 1, 0);
    chk("rock_entry", 32'(state), 32'd2);
    chk("rock_motor", 32'(motor_en), 32'd1);
    // escalation: 4 f_up take F from 5 to the ceiling, then saturation
    n_up = 0;
    repeat (4 * S) step(1, 1, 0);
    step(0, 1, 0);
    chk("fup_count", 32'(n_up), 32'd4);
    n_up = 0;
    repeat (3 * S) step(1, 1, 0);
    step(0, 1, 0);
    chk("fup_saturated", 32'(n_up), 32'd0);
    chk("sat_state", 32'(state), 32'd2);
    // calm down from F=2, A=3
    dp_f = 2;
    dp_a = 3;
    repeat (3) step(0, 0, 0);
    repeat (S) step(1, 0, 0);
    step(0, 0, 0);
    chk("calm_entry", 32'(state), 32'd3);
    n_dn = 0;
    n_ad = 0;
    repeat (6 * C) step(1, 0, 0);
    step(0, 0, 0);
    chk("fdown_count", 32'(n_dn), 32'd2);
    chk("adown_count", 32'(n_ad), 32'd3);
    chk("calm_idle", 32'(state), 32'd0);
    chk("idle_motor", 32'(motor_en), 32'd0);
    // cry returns on the very cycle of a CALM decision
    repeat (4) step(0, 1, 0);
    chk("rock_again", 32'(state), 32'd2);
    repeat (3) step(0, 0, 0);
    repeat (S) step(1, 0, 0);
    step(0, 0, 0);
    chk("calm_again", 32'(state), 32'd3);
    n_dn = 0;
    n_ad = 0;
    for (int i = 0; i < C; i++) step(1, i >= C - 3, 0);
    chk("preempt_state", 32'(state), 32'd2);
    chk("preempt_pulses", 32'(n_dn + n_ad), 32'd0);
    n_up = 0;
    repeat (S - 1) step(1, 1, 0);
    step(0, 1, 0);
    chk("timer_restart_early", 32'(n_up), 32'd0);
    step(1, 1, 0);
    step(0, 1, 0);
    chk("timer_restart_fire", 32'(n_up), 32'd1);
    // reset landing on an f_up cycle
    got = 0;
    for (int i = 0; i < 5 * S && got == 0; i++) begin
      step(1, 1, 0);
      if (f_up === 1'b1) got = 1;
    end
    chk("fup_seen", 32'(got), 32'd1);
    step(0, 0, 1);
    chk("rst_pulse_state", 32'(state), 32'd0);
    chk("rst_pulse_outs", 32'({dp_reset, f_up, f_down, a_down, motor_en}), 32'd0);
    n_up = 0;
    n_dn = 0;
    n_ad = 0;
    n_dp = 0;
    repeat (3 * S) step(1, 0, 0);
    chk("quiet_after_reset", 32'(n_up + n_dn + n_ad + n_dp), 32'd0);
    // random stress
    crv = 0;
    repeat (4000) begin
      if ($urandom_range(0, 39) == 0) crv = ~crv;
      step($urandom_range(0, 2) == 0, crv, $urandom_range(0, 299) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
